// File: rtl/frequency_analyzer_sequencer.sv
// frequency_analyzer_sequencer: runs clear/start/window/stop measurement cycles on the analyzer,
// then reads its result registers over AXI4-Lite and streams them out.
module frequency_analyzer_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 10,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int RESULT_BASE_ADDR = 0,
    parameter int RESULT_COUNT = 6,
    parameter int PULSE_CYCLES = 4,
    parameter int IRQ_TIMEOUT = 1000000
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic                          cfg_enable,
    input  logic                          cfg_continuous,
    input  logic [31:0]                   cfg_window,
    input  logic                          err_clear,
    output logic                          an_clear,
    output logic                          an_start,
    output logic                          an_stop,
    input  logic                          an_irq,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [31:0]                   result_data,
    output logic [7:0]                    result_index,
    output logic                          result_last,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_error,
    output logic                          resp_error
);
    typedef enum logic [3:0] {IDLE, CLEAR, START, WINDOW, STOP, WAIT_IRQ, READ_ADDR, READ_DATA, EMIT, DONE} state_t;
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(IRQ_TIMEOUT - 1);
    localparam logic [7:0] LAST_IDX = 8'(RESULT_COUNT - 1);
    state_t state, nxt;
    logic [31:0] cnt, win;
    logic [7:0] idx, idx_n;
    logic run_start, timeout_hit, resp_hit;
    assign m_axi_arprot = 3'b000;
    assign result_index = idx;
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (cfg_enable) nxt = CLEAR;
            CLEAR:     if (cnt == PULSE_LAST) nxt = START;
            START:     if (cnt == PULSE_LAST) nxt = WINDOW;
            WINDOW:    if (cnt == win - 32'd1) nxt = STOP;
            STOP:      if (cnt == PULSE_LAST) nxt = WAIT_IRQ;
            WAIT_IRQ:  nxt = an_irq ? READ_ADDR : (cnt == TIMEOUT_LAST) ? IDLE : WAIT_IRQ;
            READ_ADDR: if (m_axi_arready) nxt = READ_DATA;
            READ_DATA: if (m_axi_rvalid) nxt = EMIT;
            EMIT:      if (result_ready) nxt = result_last ? DONE : READ_ADDR;
            DONE:      nxt = (cfg_continuous && cfg_enable) ? CLEAR : IDLE;
            default:   nxt = IDLE;
        endcase
    end
    assign run_start = (nxt == CLEAR) && (state != CLEAR);
    assign timeout_hit = (state == WAIT_IRQ) && !an_irq && (cnt == TIMEOUT_LAST);
    assign resp_hit = (state == READ_DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00);
    assign idx_n = (state == WAIT_IRQ) ? 8'd0 :
                   (state == EMIT && result_ready && !result_last) ? idx + 8'd1 : idx;
    // Every output is registered from the next state so strobes are glitch-free and never overlap.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            cnt <= '0;
            win <= '0;
            idx <= '0;
            an_clear <= 1'b0;
            an_start <= 1'b0;
            an_stop <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_rready <= 1'b0;
            result_valid <= 1'b0;
            result_data <= '0;
            result_last <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            timeout_error <= 1'b0;
            resp_error <= 1'b0;
        end else begin
            cnt <= (nxt != state) ? 32'd0 : cnt + 32'd1;
            if (run_start) win <= (cfg_window == 32'd0) ? 32'd1 : cfg_window;
            idx <= idx_n;
            an_clear <= nxt == CLEAR;
            an_start <= nxt == START;
            an_stop <= nxt == STOP;
            m_axi_arvalid <= nxt == READ_ADDR;
            if (nxt == READ_ADDR) m_axi_araddr <= C_M_AXI_ADDR_WIDTH'(RESULT_BASE_ADDR + 4 * int'(idx_n));
            m_axi_rready <= nxt == READ_DATA;
            if (state == READ_DATA && m_axi_rvalid) result_data <= m_axi_rdata[31:0];
            result_valid <= nxt == EMIT;
            result_last <= (nxt == EMIT) && (idx_n == LAST_IDX);
            busy <= nxt != IDLE;
            done <= nxt == DONE;
            timeout_error <= timeout_hit | (timeout_error & ~err_clear);
            resp_error <= resp_hit | (resp_error & ~err_clear);
        end
    end
endmodule

// File: doc/frequency_analyzer_sequencer.md
Name: frequency_analyzer_sequencer

Overview:
Controller that runs measurement cycles on frequency_analyzer_manager. It pulses clear, start and stop around a programmable measurement window, then waits for the analyzer irq. It then reads RESULT_COUNT result registers over an AXI4-Lite read-master channel and forwards each word on a valid/ready result stream. It sits beside the analyzer, drives its clear/start/stop/irq pins, and masters its s00_axi read channel.

Parameters:
C_M_AXI_ADDR_WIDTH, 10, AXI read address width
C_M_AXI_DATA_WIDTH, 32, AXI read data width
RESULT_BASE_ADDR, 0, byte address of first result register
RESULT_COUNT, 6, number of consecutive 32-bit result registers read per run (>=1)
PULSE_CYCLES, 4, length of clear/start/stop pulses in clocks, so the slower pixel_clock domain can sample them (>=1)
IRQ_TIMEOUT, 1000000, clocks to wait for irq before aborting (>=1)

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_aresetn  in  1  asynchronous active-low reset
cfg_enable  in  1  run request, level
cfg_continuous  in  1  1 = start next run automatically after DONE
cfg_window  in  32  measurement window length in clocks
err_clear  in  1  clears sticky error flags
an_clear / an_start / an_stop  out  1 each  to analyzer clear/start/stop
an_irq  in  1  analyzer irq, level
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address
m_axi_arprot  out  3  constant 3'b000
m_axi_arvalid / m_axi_arready  out/in  1  AR handshake
m_axi_rdata  in  C_M_AXI_DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid / m_axi_rready  in/out  1  R handshake
result_valid / result_ready  out/in  1  result stream handshake
result_data  out  32  captured register value
result_index  out  8  register index 0..RESULT_COUNT-1
result_last  out  1  high with the final index
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run completion
timeout_error / resp_error  out  1 each  sticky error flags

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters and index 0; result_data 0.
- IDLE: cfg_enable=1 latches cfg_window (0 is treated as 1) -> CLEAR.
- CLEAR: an_clear=1 for exactly PULSE_CYCLES clocks -> START.
- START: an_start=1 for PULSE_CYCLES clocks -> WINDOW.
- WINDOW: all strobes 0 for exactly latched-window clocks -> STOP.
- STOP: an_stop=1 for PULSE_CYCLES clocks -> WAIT_IRQ. The timeout counter resets on entry.
- Strobes never overlap, and each is registered (glitch-free).
- WAIT_IRQ, irq sampled 1 (including already high on entry): index=0 -> READ_ADDR.
- WAIT_IRQ, IRQ_TIMEOUT clocks without irq: set timeout_error -> IDLE. No reads, no done pulse.
- READ_ADDR: arvalid=1, araddr = RESULT_BASE_ADDR + 4*index, stable until arready sampled high. arvalid=0 the following cycle -> READ_DATA.
- READ_DATA: rready=1. On rvalid: capture rdata into result_data, rready drops -> EMIT. If rresp != 0, set resp_error; the data is still emitted.
- EMIT: result_valid=1, result_index=index, result_last=(index==RESULT_COUNT-1). data/index/last stay stable until result_ready.
- EMIT, on handshake: last -> DONE, else index+1 -> READ_ADDR. The next AR never issues while result_valid is pending. Zero bubbles are not required.
- DONE: done=1 for one clock. cfg_continuous & cfg_enable -> CLEAR (new window re-latched); else -> IDLE.
- cfg_enable low mid-run: no abort. The run finishes, then returns to IDLE (continuous ignored). Config inputs change only at latch points.
- An AXI transaction, once started, is never abandoned except by reset. Reset mid-transaction drops arvalid/rready immediately.
- Sticky errors clear on err_clear=1. A set and err_clear in the same cycle: set wins.
- Latency: enable -> an_clear high is 1 clock. an_irq high in WAIT_IRQ -> arvalid is 1 clock.

Test Plan:
- PULSE_CYCLES=4, window=10, irq asserted 5 clocks after STOP, arready/rvalid immediate, result_ready=1 -> clear, start and stop each high 4 clocks, with 10 idle clocks between start fall and stop rise. Reads go to 0x00,0x04,...,0x14; 6 results index 0..5 with last only on 5; done one pulse; busy falls after.
- Backpressure: arready delayed 3 clocks, rvalid delayed 2, result_ready held low 5 clocks on index 2 -> araddr/arvalid stable, result_data/index stable, no extra AR issued, every word emitted exactly once.
- irq never asserted, IRQ_TIMEOUT=50 -> timeout_error set 50 clocks after WAIT_IRQ entry; returns to IDLE with no arvalid and no done. err_clear then clears the flag.
- rresp=2'b10 on index 3 -> resp_error set, index 3 data still emitted, run completes with done. err_clear coinciding with a new error leaves the flag 1.
- cfg_continuous=1, then cfg_enable dropped during the second run's WINDOW -> second run completes with 6 results and done; then IDLE, no third clear.
- s00_axi_aresetn pulsed low while arvalid=1 -> all outputs 0 asynchronously, IDLE. After release with enable=1, a fresh clear pulse follows.
